host_io: RTL and testbench
==========================

HOST_IO -- requirements
Module: host_io

Interface
REQ-001 Parameter NCHAN, 1, number of console channels (legal 1..4).
REQ-002 Parameter FIFO_DEPTH, 8, bytes per channel FIFO (power of two, 2..64).
REQ-003 Parameter PUTC_ADDR, 32'h9000001c, channel k write address = PUTC_ADDR + 4*k.
REQ-004 Parameter EXIT_ADDR, 32'h9000002c, exit register address.
REQ-005 Parameter MEM_SIZE, 262144, bytes of legal backing memory starting at address 0 (power of two).
REQ-006 Parameter TIMEOUT, 100, PC-unchanged cycles before timeout.
REQ-007 clk  input  1  single clock, all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 wready  input  1  write strobe from core, one write per high cycle.
REQ-010 waddr  input  32  write byte address.
REQ-011 wdata  input  32  write data; console byte is wdata[7:0], wstrb ignored.
REQ-012 mem_wready  output  1  write strobe forwarded to memory.
REQ-013 tx_valid / tx_ready  output / input  1 / 1  console byte handshake.
REQ-014 tx_chan / tx_data  output  2 / 8  source channel and byte.
REQ-015 pc  input  32  fetch PC for watchdog.
REQ-016 exit_done / exit_code  output  1 / 32  program finished, latched exit value.
REQ-017 range_err / err_addr  output  1 / 32  sticky out-of-range flag, first offending address.
REQ-018 ovf  output  NCHAN  per-channel sticky FIFO overflow.
REQ-019 timeout  output  1  sticky watchdog expiry.

Function
REQ-020 Device hit = wready and waddr equals a channel address (k<NCHAN) or EXIT_ADDR; mem_wready = wready & ~hit, combinational.
REQ-021 Channel hit pushes wdata[7:0] into that channel's FIFO at the clock edge; FIFO byte visible at tx earliest next cycle.
REQ-022 Push to full FIFO dropped and ovf[k] set, even if a pop of that FIFO occurs the same cycle.
REQ-023 Drain: round-robin over non-empty FIFOs, search starts at channel after last granted; tx_chan/tx_data/tx_valid held stable while tx_valid & ~tx_ready.
REQ-024 Pop occurs only on tx_valid & tx_ready; push and pop to same non-full FIFO same cycle both succeed, occupancy unchanged.
REQ-025 EXIT hit latches exit_code = wdata and sets exit_pending; further EXIT hits ignored.
REQ-026 Channel pushes after exit_pending are dropped without setting ovf.
REQ-027 exit_done rises the cycle after exit_pending is set and all FIFOs are empty with no tx_valid; sticky.
REQ-028 Non-hit wready with waddr >= MEM_SIZE sets range_err and latches err_addr on first occurrence only; mem_wready still asserted.
REQ-029 Channel addresses for k >= NCHAN are not hits and fall to the range check.

Reset
REQ-030 Asserting reset at any time, including mid-handshake, empties all FIFOs, clears round-robin pointer to channel 0, and zeroes tx_valid, tx_chan, tx_data, exit_done, exit_code, range_err, err_addr, ovf, timeout and watchdog state.
REQ-031 After reset deasserts, first edge is a normal operating cycle.

Configuration
REQ-032 Macro HOST_IO_WDOG_EN defined: counter tracks pc; increments when pc equals previous-cycle pc, clears on change; timeout set when count > TIMEOUT; counter saturates.
REQ-033 HOST_IO_WDOG_EN undefined: no counter logic, pc unused, timeout tied 0.

Verification
REQ-034 NCHAN=1: write 0x41,0x42 to 0x9000001c, tx_ready=1 -> tx_data 0x41 then 0x42, tx_chan 0, mem_wready low both writes.
REQ-035 NCHAN=3, each channel loaded 2 bytes, tx_ready=1 -> tx_chan sequence 0,1,2,0,1,2; tx_ready low 5 cycles mid-stream -> outputs stable.
REQ-036 FIFO_DEPTH=8, tx_ready=0, 9 writes to channel 0 -> ovf[0]=1, 8 bytes later drained, ninth absent.
REQ-037 3 bytes queued, tx_ready=0, write 0x7 to 0x9000002c -> exit_done 0; raise tx_ready -> exit_done=1 the cycle after third byte accepted, exit_code 0x7.
REQ-038 Write to 0x00040000 then 0x00050000 -> range_err=1, err_addr 0x00040000, mem_wready high both.
REQ-039 HOST_IO_WDOG_EN defined, pc held constant -> timeout=1 after 102 cycles; pc change earlier clears count; reset asserted mid-count -> timeout 0.

Source files
------------

// File: rtl/host_io_if.sv
// host_io_if: core-side write bus plus console byte stream of the host I/O block.
// master = core / console sink side, slave = host_io.
interface host_io_if;
  // write bus from the core
  logic        wready;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        mem_wready;
  // console byte stream
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  tx_chan;
  logic [7:0]  tx_data;

  modport master (
    output wready, waddr, wdata, tx_ready,
    input  mem_wready, tx_valid, tx_chan, tx_data
  );

  modport slave (
    input  wready, waddr, wdata, tx_ready,
    output mem_wready, tx_valid, tx_chan, tx_data
  );
endinterface

// File: rtl/host_io.sv
// host_io: memory-mapped host I/O for a simulated core.
//  - Decodes console (PUTC) and EXIT writes off the core write bus and forwards
//    all other writes to memory.
//  - One byte FIFO per console channel, drained round-robin onto tx_*.
//  - Exit register, out-of-range write detection, per-channel overflow flags.
//  - Optional PC watchdog, compiled in only when HOST_IO_WDOG_EN is defined.
module host_io #(
  parameter int          NCHAN      = 1,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] PUTC_ADDR  = 32'h9000001c,
  parameter logic [31:0] EXIT_ADDR  = 32'h9000002c,
  parameter int          MEM_SIZE   = 262144,
  parameter int          TIMEOUT    = 100
) (
  input  logic             clk,
  input  logic             reset,
  host_io_if.slave         bus,
  input  logic [31:0]      pc,
  output logic             exit_done,
  output logic [31:0]      exit_code,
  output logic             range_err,
  output logic [31:0]      err_addr,
  output logic [NCHAN-1:0] ovf,
  output logic             timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // decode / FIFO status, one bit per implemented channel
  logic [NCHAN-1:0] chan_hit;
  logic [NCHAN-1:0] push_ok;
  logic [NCHAN-1:0] ovf_set;
  logic [NCHAN-1:0] pop;
  logic [NCHAN-1:0] nonempty;
  logic [NCHAN-1:0] nonempty_next;
  logic [3:0]       nonempty_next4;
  logic [7:0]       head [4];

  logic exit_hit;
  logic dev_hit;
  logic handshake;
  logic advance;
  logic all_empty;

  // output stage and round-robin state
  logic       tx_valid_reg;
  logic [1:0] tx_chan_reg;
  logic [1:0] rr_reg;
  logic       grant_found;
  logic [1:0] grant_chan;
  logic [1:0] rr_after;
  logic [2:0] cand;
  logic [2:0] rr_inc;

  // exit / error state
  logic             exit_pending_reg;
  logic             exit_done_reg;
  logic [31:0]      exit_code_reg;
  logic             range_err_reg;
  logic [31:0]      err_addr_reg;
  logic [NCHAN-1:0] ovf_reg;

  // ---------------------------------------------------------------------------
  // Address decode. Only channels below NCHAN decode; higher channel addresses
  // are ordinary writes and go through the range check.
  // ---------------------------------------------------------------------------
  assign exit_hit       = bus.wready && (bus.waddr == EXIT_ADDR);
  assign dev_hit        = (|chan_hit) || exit_hit;
  assign bus.mem_wready = bus.wready && !dev_hit;

  // The byte on tx is still held in its FIFO; it only leaves on a handshake.
  assign handshake = tx_valid_reg && bus.tx_ready;
  assign advance   = !tx_valid_reg || bus.tx_ready;

  // ---------------------------------------------------------------------------
  // Per-channel FIFOs. Pointers carry one extra wrap bit so that full and empty
  // are told apart without a separate count register. A push is judged against
  // the occupancy before any same-cycle pop, so a full FIFO drops the byte even
  // while it is being drained.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_chan
    if (gi < NCHAN) begin : g_fifo
      logic [7:0]    mem [FIFO_DEPTH];
      logic [CW-1:0] wr_ptr_reg;
      logic [CW-1:0] rd_ptr_reg;
      logic [CW-1:0] count;
      logic [CW-1:0] count_next;
      logic          full;

      assign chan_hit[gi]      = bus.wready && (bus.waddr == PUTC_ADDR + 32'(4 * gi));
      assign count             = wr_ptr_reg - rd_ptr_reg;
      assign full              = (count == CW'(FIFO_DEPTH));
      assign nonempty[gi]      = (count != '0);
      assign push_ok[gi]       = chan_hit[gi] && !full && !exit_pending_reg;
      assign ovf_set[gi]       = chan_hit[gi] && full && !exit_pending_reg;
      assign pop[gi]           = handshake && (tx_chan_reg == 2'(gi));
      assign count_next        = count + CW'(push_ok[gi]) - CW'(pop[gi]);
      assign nonempty_next[gi] = (count_next != '0);
      assign head[gi]          = mem[rd_ptr_reg[AW-1:0]];

      // advance write pointer on accepted push, read pointer on handshake
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (push_ok[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi])     rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
      end

      // byte storage; only free slots are ever written, so the head is stable
      always_ff @(posedge clk) begin
        if (push_ok[gi]) mem[wr_ptr_reg[AW-1:0]] <= bus.wdata[7:0];
      end
    end else begin : g_none
      assign head[gi] = 8'h00;
    end
  end

  assign all_empty      = !(|nonempty);
  assign nonempty_next4 = 4'(nonempty_next);

  // ---------------------------------------------------------------------------
  // Round-robin selection over the FIFO state as it will be after this edge,
  // so a byte pushed now can be presented on tx in the very next cycle.
  // rr_reg holds the channel the search starts from (one past the last grant).
  // ---------------------------------------------------------------------------
  // pick first non-empty channel starting at rr_reg
  always_comb begin
    grant_found = 1'b0;
    grant_chan  = 2'd0;
    cand        = 3'd0;
    rr_inc      = 3'd0;
    rr_after    = rr_reg;
    for (int i = 0; i < NCHAN; i++) begin
      cand = {1'b0, rr_reg} + 3'(i);
      if (cand >= 3'(NCHAN)) cand = cand - 3'(NCHAN);
      if (!grant_found && nonempty_next4[cand[1:0]]) begin
        grant_found = 1'b1;
        grant_chan  = cand[1:0];
      end
    end
    rr_inc = {1'b0, grant_chan} + 3'd1;
    if (rr_inc >= 3'(NCHAN)) rr_inc = 3'd0;
    rr_after = rr_inc[1:0];
  end

  // tx output stage: reselect only when idle or the current byte is taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_valid_reg <= 1'b0;
      tx_chan_reg  <= 2'd0;
      rr_reg       <= 2'd0;
    end else if (advance) begin
      tx_valid_reg <= grant_found;
      if (grant_found) begin
        tx_chan_reg <= grant_chan;
        rr_reg      <= rr_after;
      end
    end
  end

  assign bus.tx_valid = tx_valid_reg;
  assign bus.tx_chan  = tx_chan_reg;
  assign bus.tx_data  = tx_valid_reg ? head[tx_chan_reg] : 8'h00;

  // ---------------------------------------------------------------------------
  // Exit handling. The first EXIT write wins; afterwards console pushes are
  // silently discarded. exit_done is registered off the current state: it rises
  // one cycle after the cycle in which everything is drained and tx is idle.
  // ---------------------------------------------------------------------------
  // latch exit code and track completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exit_pending_reg <= 1'b0;
      exit_code_reg    <= 32'h0;
      exit_done_reg    <= 1'b0;
    end else begin
      if (exit_hit && !exit_pending_reg) begin
        exit_pending_reg <= 1'b1;
        exit_code_reg    <= bus.wdata;
      end
      if (exit_pending_reg && all_empty && !tx_valid_reg) exit_done_reg <= 1'b1;
    end
  end

  // sticky out-of-range flag holding the first offending address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      range_err_reg <= 1'b0;
      err_addr_reg  <= 32'h0;
    end else if (bus.wready && !dev_hit && (bus.waddr >= 32'(MEM_SIZE)) && !range_err_reg) begin
      range_err_reg <= 1'b1;
      err_addr_reg  <= bus.waddr;
    end
  end

  // sticky per-channel overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_reg <= '0;
    else       ovf_reg <= ovf_reg | ovf_set;
  end

  assign exit_done = exit_done_reg;
  assign exit_code = exit_code_reg;
  assign range_err = range_err_reg;
  assign err_addr  = err_addr_reg;
  assign ovf       = ovf_reg;

  // ---------------------------------------------------------------------------
  // PC watchdog. The counter saturates one above TIMEOUT so it can never wrap
  // back below the trip point.
  // ---------------------------------------------------------------------------
`ifdef HOST_IO_WDOG_EN
  localparam int WW = $clog2(TIMEOUT + 2) + 1;

  logic [31:0]   prev_pc_reg;
  logic [WW-1:0] wd_cnt_reg;
  logic [WW-1:0] wd_cnt_next;
  logic          timeout_reg;

  // count consecutive cycles with an unchanged pc
  always_comb begin
    wd_cnt_next = wd_cnt_reg;
    if (pc != prev_pc_reg)             wd_cnt_next = '0;
    else if (wd_cnt_reg <= WW'(TIMEOUT)) wd_cnt_next = wd_cnt_reg + 1'b1;
  end

  // watchdog state and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_pc_reg <= 32'h0;
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      prev_pc_reg <= pc;
      wd_cnt_reg  <= wd_cnt_next;
      if (wd_cnt_next > WW'(TIMEOUT)) timeout_reg <= 1'b1;
    end
  end

  assign timeout = timeout_reg;
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_host_io.sv
// tb_host_io: randomized + directed bench for host_io (NCHAN=3, FIFO_DEPTH=8).
// A queue-based reference model steps on every clock edge; a compare process
// checks every DUT output against it at each falling edge. Directed scenarios
// add hand-computed literal expectations. Define HOST_IO_WDOG_EN to also
// exercise the watchdog.
`timescale 1ns/1ps
module tb_host_io;
  localparam int          NCHAN    = 3;
  localparam int          DEPTH    = 8;
  localparam int          TIMEOUT  = 100;
  localparam int          MEM_SIZE = 262144;
  localparam logic [31:0] PUTC     = 32'h9000001c;
  localparam logic [31:0] EXITA    = 32'h9000002c;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      pc = 32'h0;
  logic             exit_done;
  logic [31:0]      exit_code;
  logic             range_err;
  logic [31:0]      err_addr;
  logic [NCHAN-1:0] ovf;
  logic             timeout;

  host_io_if bus ();

  host_io #(.NCHAN(NCHAN), .FIFO_DEPTH(DEPTH), .PUTC_ADDR(PUTC), .EXIT_ADDR(EXITA),
            .MEM_SIZE(MEM_SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .pc(pc),
    .exit_done(exit_done), .exit_code(exit_code),
    .range_err(range_err), .err_addr(err_addr),
    .ovf(ovf), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int chan_of(input logic [31:0] a);
    for (int k = 0; k < NCHAN; k++)
      if (a == PUTC + 32'(4 * k)) return k;
    return -1;
  endfunction

  // ------------------------------------------------------------------ model
  logic [7:0]  mq [NCHAN][$];
  bit          m_valid, m_pend, m_done, m_rerr, m_tmo;
  int          m_chan, m_rr, m_wcnt;
  logic [31:0] m_code, m_eaddr, m_prev;
  bit [NCHAN-1:0] m_ovf;
  int          m_hit;
  bit          m_exit_h, m_hs, m_idle;
  bit          m_full [NCHAN];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCHAN; c++) mq[c].delete();
      m_valid = 0; m_pend = 0; m_done = 0; m_rerr = 0; m_tmo = 0;
      m_chan = 0; m_rr = 0; m_wcnt = 0;
      m_code = 0; m_eaddr = 0; m_prev = 0; m_ovf = '0;
    end else begin
      // completion is judged on the state before this edge
      m_idle = !m_valid;
      for (int c = 0; c < NCHAN; c++) begin
        if (mq[c].size() != 0) m_idle = 0;
        m_full[c] = (mq[c].size() == DEPTH);
      end
      if (m_pend && m_idle) m_done = 1;
      m_hs = m_valid && bus.tx_ready;
      if (m_hs) void'(mq[m_chan].pop_front());
      m_hit    = bus.wready ? chan_of(bus.waddr) : -1;
      m_exit_h = bus.wready && (bus.waddr == EXITA);
      if (m_hit >= 0 && !m_pend) begin
        if (m_full[m_hit]) m_ovf[m_hit] = 1;
        else               mq[m_hit].push_back(bus.wdata[7:0]);
      end
      if (m_exit_h && !m_pend) begin
        m_pend = 1;
        m_code = bus.wdata;
      end
      if (bus.wready && m_hit < 0 && !m_exit_h && bus.waddr >= 32'(MEM_SIZE) && !m_rerr) begin
        m_rerr  = 1;
        m_eaddr = bus.waddr;
      end
      if (!m_valid || m_hs) begin
        m_valid = 0;
        for (int i = 0; i < NCHAN; i++) begin
          if (!m_valid && mq[(m_rr + i) % NCHAN].size() != 0) begin
            m_valid = 1;
            m_chan  = (m_rr + i) % NCHAN;
          end
        end
        if (m_valid) m_rr = (m_chan + 1) % NCHAN;
      end
`ifdef HOST_IO_WDOG_EN
      if (pc == m_prev) m_wcnt++;
      else              m_wcnt = 0;
      m_prev = pc;
      if (m_wcnt > TIMEOUT) m_tmo = 1;
`endif
    end
  end

  // ---------------------------------------------------------------- compare
  always @(negedge clk) begin
    chk("mem_wready", 32'(bus.mem_wready),
        32'(bus.wready && chan_of(bus.waddr) < 0 && bus.waddr != EXITA));
    chk("tx_valid", 32'(bus.tx_valid), 32'(m_valid));
    if (m_valid) begin
      chk("tx_chan", 32'(bus.tx_chan), 32'(m_chan));
      chk("tx_data", 32'(bus.tx_data), 32'(mq[m_chan][0]));
    end
    chk("exit_done", 32'(exit_done), 32'(m_done));
    chk("exit_code", exit_code, m_code);
    chk("range_err", 32'(range_err), 32'(m_rerr));
    chk("err_addr", err_addr, m_eaddr);
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("timeout", 32'(timeout), 32'(m_tmo));
  end

  // ------------------------------------------------------------- stimulus
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.wready   = 0;
    bus.tx_ready = 0;
    reset = 1;
    cyc();
    cyc();
    reset = 0;
  endtask

  // one write, checking the combinational mem_wready against a literal
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic exp_mw);
    bus.wready = 1;
    bus.waddr  = a;
    bus.wdata  = d;
    #2;
    chk("wr_mem_wready", 32'(bus.mem_wready), 32'(exp_mw));
    $display("[TB] write addr=0x%08h data=0x%08h mem_wready=%0d", a, d, bus.mem_wready);
    cyc();
    bus.wready = 0;
  endtask

  logic [7:0] got [$];
  logic [1:0] gch [$];
  int         seen;
  int         ready_pct;
  int         r;
  bit         stalled;

  initial begin
    bus.wready = 0; bus.waddr = 0; bus.wdata = 0; bus.tx_ready = 0;
    cyc();
    // reset state
    chk("rst_tx_valid", 32'(bus.tx_valid), 0);
    chk("rst_tx_chan", 32'(bus.tx_chan), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_timeout", 32'(timeout), 0);
    do_reset();

    // two bytes on channel 0 with the sink always ready
    bus.tx_ready = 1;
    wr(PUTC, 32'h41, 0);
    chk("c0_first_valid", 32'(bus.tx_valid), 1);
    chk("c0_first_data", 32'(bus.tx_data), 32'h41);
    wr(PUTC, 32'h42, 0);
    chk("c0_second_data", 32'(bus.tx_data), 32'h42);
    chk("c0_second_chan", 32'(bus.tx_chan), 0);
    cyc();
    chk("c0_idle", 32'(bus.tx_valid), 0);

    // round-robin over three loaded channels with a mid-stream stall
    do_reset();
    for (int k = 0; k < NCHAN; k++) begin
      wr(PUTC + 32'(4 * k), 32'(8'h50 + 2 * k), 0);
      wr(PUTC + 32'(4 * k), 32'(8'h51 + 2 * k), 0);
    end
    gch.delete();
    stalled = 0;
    bus.tx_ready = 1;
    for (int t = 0; t < 40 && gch.size() < 6; t++) begin
      if (gch.size() == 3 && !stalled) begin
        stalled = 1;
        bus.tx_ready = 0;
        for (int s = 0; s < 5; s++) begin
          cyc();
          chk("stall_valid", 32'(bus.tx_valid), 1);
          chk("stall_chan", 32'(bus.tx_chan), 0);
          chk("stall_data", 32'(bus.tx_data), 32'h51);
        end
        bus.tx_ready = 1;
      end
      if (bus.tx_valid && bus.tx_ready) gch.push_back(bus.tx_chan);
      cyc();
    end
    chk("rr_count", 32'(gch.size()), 6);
    for (int i = 0; i < gch.size(); i++) chk("rr_order", 32'(gch[i]), 32'(i % 3));

    // overflow: nine bytes into an eight-deep FIFO with the sink stalled
    do_reset();
    for (int i = 0; i < 9; i++) wr(PUTC, 32'(8'h10 + i), 0);
    chk("ovf_set", 32'(ovf), 32'b001);
    got.delete();
    bus.tx_ready = 1;
    for (int t = 0; t < 30; t++) begin
      if (bus.tx_valid) got.push_back(bus.tx_data);
      cyc();
    end
    chk("ovf_drained", 32'(got.size()), 8);
    for (int i = 0; i < got.size(); i++) chk("ovf_byte", 32'(got[i]), 32'(8'h10 + i));

    // out-of-range writes: first address is the one kept
    do_reset();
    wr(32'h0003fffc, 32'h1, 1);
    chk("range_inside", 32'(range_err), 0);
    wr(32'h00040000, 32'h2, 1);
    wr(32'h00050000, 32'h3, 1);
    chk("range_err", 32'(range_err), 1);
    chk("err_addr", err_addr, 32'h00040000);

    // randomized traffic with an asynchronous reset in the middle
    do_reset();
    ready_pct = 50;
    for (int n = 0; n < 2500; n++) begin
      if (n % 100 == 0) ready_pct = $urandom_range(0, 100);
      bus.tx_ready = ($urandom_range(0, 99) < ready_pct);
      if ($urandom_range(0, 99) < 55) begin
        r = $urandom_range(0, 99);
        bus.wready = 1;
        bus.wdata  = $urandom;
        if (r < 45)      bus.waddr = PUTC + 32'(4 * $urandom_range(0, 3));
        else if (r < 48) bus.waddr = (n > 2300) ? EXITA : PUTC;
        else if (r < 54) bus.waddr = ($urandom_range(0, 1) != 0) ? 32'(MEM_SIZE) : 32'(MEM_SIZE - 1);
        else if (r < 56) bus.waddr = $urandom;
        else             bus.waddr = 32'($urandom_range(0, MEM_SIZE - 1)) & 32'hfffffffc;
      end else begin
        bus.wready = 0;
      end
      if ($urandom_range(0, 199) == 0) pc = $urandom;
      if (n == 1200) begin
        #3;
        reset = 1;
        cyc();
        cyc();
        reset = 0;
      end else begin
        cyc();
      end
    end
    bus.wready = 0;

    // exit with bytes still queued
    do_reset();
    for (int i = 0; i < 3; i++) wr(PUTC + 32'd4, 32'(8'h60 + i), 0);
    wr(EXITA, 32'h7, 0);
    wr(PUTC, 32'hAA, 0);
    cyc();
    chk("exit_wait", 32'(exit_done), 0);
    chk("exit_no_ovf", 32'(ovf), 0);
    bus.tx_ready = 1;
    seen = 0;
    for (int t = 0; t < 50 && !exit_done; t++) begin
      if (bus.tx_valid) seen++;
      cyc();
    end
    chk("exit_bytes", 32'(seen), 3);
    chk("exit_done", 32'(exit_done), 1);
    chk("exit_code", exit_code, 32'h7);

`ifdef HOST_IO_WDOG_EN
    // constant pc trips on the 102nd edge
    do_reset();
    pc = 32'h100;
    repeat (101) cyc();
    chk("wdog_101", 32'(timeout), 0);
    cyc();
    chk("wdog_102", 32'(timeout), 1);
    // a pc change restarts the count; reset clears it
    do_reset();
    pc = 32'h200;
    repeat (60) cyc();
    pc = 32'h204;
    repeat (60) cyc();
    chk("wdog_change", 32'(timeout), 0);
    repeat (30) cyc();
    reset = 1;
    cyc();
    chk("wdog_reset", 32'(timeout), 0);
    reset = 0;
    repeat (60) cyc();
    chk("wdog_after_reset", 32'(timeout), 0);
`endif

    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL global_timeout: got no finish expected finish by 500us");
    $fatal(1, "bench time limit");
  end

endmodule
